// File: rtl/mpc_constraint_seq.sv
// rtl/mpc_constraint_seq.sv - runs NUM_STAGE constraint-fill stages in order and shares one h write port
// Optional per-stage watchdog abort: define MPC_CONSTRAINT_WDOG_EN.
module mpc_constraint_seq #(
   parameter int NUM_STAGE   = 4,
   parameter int AW          = 5,
   parameter int DW          = 21,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    ap_start,
   output logic                    ap_done,
   output logic                    ap_ready,
   output logic                    ap_idle,
   output logic [NUM_STAGE-1:0]    stg_start,
   input  logic [NUM_STAGE-1:0]    stg_done,
   input  logic [NUM_STAGE*AW-1:0] stg_h_address0,
   input  logic [NUM_STAGE-1:0]    stg_h_ce0,
   input  logic [NUM_STAGE-1:0]    stg_h_we0,
   input  logic [NUM_STAGE*DW-1:0] stg_h_d0,
   output logic [AW-1:0]           h_address0,
   output logic                    h_ce0,
   output logic                    h_we0,
   output logic [DW-1:0]           h_d0,
   output logic                    err
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       stage_done;
   logic       last_stage;
   logic       wdog_hit;

   // Only the active stage's done is ever looked at.
   assign stage_done = stg_done[idx_q];
   assign last_stage = (idx_q == 2'(NUM_STAGE - 1));

`ifdef MPC_CONSTRAINT_WDOG_EN
   localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign wdog_hit = (cnt_q == WDOG_LAST);
   assign err      = err_q;

   always_comb begin
      cnt_d = '0;
      err_d = err_q;
      if (state_q == RUN && !stage_done && !wdog_hit)
         cnt_d = cnt_q + 1'b1;
      if (state_q == IDLE && ap_start)
         err_d = 1'b0;
      else if (state_q == RUN && !stage_done && wdog_hit)
         err_d = 1'b1;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign err      = 1'b0;
`endif

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ap_idle    = 1'b0;
      ap_done    = 1'b0;
      ap_ready   = 1'b0;
      stg_start  = '0;
      h_address0 = '0;
      h_ce0      = 1'b0;
      h_we0      = 1'b0;
      h_d0       = '0;
      case (state_q)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_d = RUN;
               idx_d   = 2'd0;
            end
         end
         RUN: begin
            stg_start  = NUM_STAGE'(1) << idx_q;
            h_address0 = stg_h_address0[idx_q*AW +: AW];
            h_ce0      = stg_h_ce0[idx_q];
            h_we0      = stg_h_we0[idx_q];
            h_d0       = stg_h_d0[idx_q*DW +: DW];
            if (stage_done) begin
               if (last_stage) state_d = FIN;
               else            idx_d   = idx_q + 2'd1;
            end else if (wdog_hit) begin
               state_d = FIN;
            end
         end
         FIN: begin
            ap_done  = 1'b1;
            ap_ready = 1'b1;
            idx_d    = 2'd0;
            // A still-held start chains straight into the next sequence.
            state_d  = ap_start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

endmodule
